// File: rtl/ascii_line_sender.sv
// ascii_line_sender: serializes one "<cmd> <hex4> <bin16>[CRLF]" text line per start into a valid/ready byte stream
module ascii_line_sender #(
   parameter logic [7:0] SEP_CHAR  = 8'h20,
   parameter bit         SEND_CRLF = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   char_command,
   input  logic [31:0]  ascii_hex,
   input  logic [127:0] ascii_bin,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   localparam logic [4:0] LAST = SEND_CRLF ? 5'd24 : 5'd22;
   state_t       state, state_n;
   logic [4:0]   idx, idx_n;
   logic [167:0] shadow, shadow_n;
   logic [7:0]   data_n;
   logic [7:0]   seq [25];
   assign tx_valid = state == SEND;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   // state, index, captured line and the registered output byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         shadow  <= '0;
         tx_data <= '0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         shadow  <= shadow_n;
         tx_data <= data_n;
      end
   end
   // next state: capture on start in IDLE, advance on each accepted byte, one DONE cycle
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      shadow_n = shadow;
      if (state == IDLE && start) begin
         shadow_n = {char_command, ascii_hex, ascii_bin};
         idx_n    = '0;
         state_n  = SEND;
      end else if (state == SEND && tx_ready) begin
         state_n = (idx == LAST) ? DONE : SEND;
         idx_n   = (idx == LAST) ? idx : idx + 5'd1;
      end else if (state == DONE) begin
         state_n = IDLE;
      end
   end
   // byte layout of the line, built from the next shadow value so byte 0 is ready right after capture
   always_comb begin
      seq[0]  = shadow_n[167:160];
      seq[1]  = SEP_CHAR;
      seq[6]  = SEP_CHAR;
      seq[23] = 8'h0D;
      seq[24] = 8'h0A;
      for (int i = 0; i < 4; i++) seq[2+i] = shadow_n[159-8*i -: 8];
      for (int i = 0; i < 16; i++) seq[7+i] = shadow_n[127-8*i -: 8];
      data_n = (state_n == SEND) ? seq[idx_n] : tx_data;
   end
endmodule

// File: tb/tb_ascii_line_sender.sv
// tb_ascii_line_sender: directed checks of byte order, handshake, capture, reset and back-to-back timing
module tb_ascii_line_sender;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0, start0 = 1'b0;
   logic [7:0]   char_command = '0;
   logic [31:0]  ascii_hex = '0;
   logic [127:0] ascii_bin = '0;
   logic         tx_ready = 1'b0;
   logic [7:0]   tx_data, tx_data0, m_data;
   logic         tx_valid, tx_valid0, busy, busy0, done, done0, m_valid, m_busy, m_done;
   logic         sel = 1'b0;
   int           n_checks = 0, n_fail = 0;
   logic [7:0]   got [$];
   logic [7:0]   exp_q [$];
   int           stalls_bad, dones, last_c, done_c;
   logic [7:0]   exp_basic [25] = '{8'h2B, 8'h20, 8'h41, 8'h35, 8'h43, 8'h33, 8'h20,
                                   8'h31, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h31,
                                   8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h31,
                                   8'h0D, 8'h0A};

   ascii_line_sender #(.SEP_CHAR(8'h20), .SEND_CRLF(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .char_command(char_command),
      .ascii_hex(ascii_hex), .ascii_bin(ascii_bin), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));
   ascii_line_sender #(.SEP_CHAR(8'h20), .SEND_CRLF(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .char_command(char_command),
      .ascii_hex(ascii_hex), .ascii_bin(ascii_bin), .tx_data(tx_data0),
      .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .done(done0));

   assign m_data  = sel ? tx_data0 : tx_data;
   assign m_valid = sel ? tx_valid0 : tx_valid;
   assign m_busy  = sel ? busy0 : busy;
   assign m_done  = sel ? done0 : done;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [7:0] c, input logic [31:0] h,
                                             input logic [127:0] b, input int i);
      if (i == 0) return c;
      if (i == 1 || i == 6) return 8'h20;
      if (i >= 2 && i <= 5) return h[31-8*(i-2) -: 8];
      if (i >= 7 && i <= 22) return b[127-8*(i-7) -: 8];
      return (i == 23) ? 8'h0D : 8'h0A;
   endfunction

   task automatic build_exp(input logic [7:0] c, input logic [31:0] h, input logic [127:0] b, input int len);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(model_byte(c, h, b, i));
   endtask

   // at a negedge: raise start for one edge and return at the next negedge
   task automatic pulse_start(input bit which);
      if (which) start0 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start0 = 1'b0;
   endtask

   // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready high, new inputs and start at c=10
   task automatic collect(input int mode);
      logic pv = 1'b0, pr = 1'b0;
      logic [7:0] pd = '0;
      bit finished = 1'b0;
      got.delete();
      stalls_bad = 0; dones = 0; last_c = -1; done_c = -1;
      for (int c = 0; c < 300; c++) begin
         tx_ready = (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
         if (mode == 2 && c == 10) begin
            char_command = 8'h2D; ascii_hex = "0000"; ascii_bin = "0000000000000000"; start = 1'b1;
         end
         if (mode == 2 && c == 11) start = 1'b0;
         if (m_done) begin dones++; done_c = c; end
         if (!m_busy && dones > 0) begin finished = 1'b1; break; end
         if (pv && !pr && (!m_valid || m_data !== pd)) stalls_bad++;
         if (m_valid && tx_ready) begin got.push_back(m_data); last_c = c; end
         pv = m_valid; pr = tx_ready; pd = m_data;
         @(negedge clk);
      end
      check("line_finished", {31'd0, finished}, 32'd1);
   endtask

   task automatic compare_line(input string tag);
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
      check({tag, "_done_once"}, dones, 1);
      check({tag, "_done_after_last"}, done_c - last_c, 1);
   endtask

   initial begin
      int starts [$];
      int vcnt;
      logic pv;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      // basic line, ready always high
      char_command = 8'h2B; ascii_hex = "A5C3"; ascii_bin = "1010010111000011";
      exp_q.delete();
      foreach (exp_basic[i]) exp_q.push_back(exp_basic[i]);
      pulse_start(1'b0);
      check("lat_valid", {31'd0, tx_valid}, 32'd1);
      check("lat_byte0", {24'd0, tx_data}, 32'h2B);
      check("lat_busy", {31'd0, busy}, 32'd1);
      collect(0);
      compare_line("basic");
      check("basic_busy_after", {31'd0, busy}, 32'd0);
      // backpressure
      pulse_start(1'b0);
      collect(1);
      compare_line("bp");
      check("bp_stall_stable", stalls_bad, 0);
      // input change and ignored start mid-line
      char_command = 8'h2B; ascii_hex = "A5C3"; ascii_bin = "1010010111000011";
      pulse_start(1'b0);
      collect(2);
      compare_line("chg");
      vcnt = 0;
      repeat (6) begin
         if (busy || tx_valid) vcnt++;
         @(negedge clk);
      end
      check("chg_no_second_line", vcnt, 0);
      // reset mid-line at idx 12
      pulse_start(1'b0);
      tx_ready = 1'b1;
      repeat (12) @(negedge clk);
      check("pre_rst_byte12", {24'd0, tx_data}, {24'd0, model_byte(8'h2D, "0000", "0000000000000000", 12)});
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {31'd0, busy}, 32'd0);
      char_command = 8'h2A; ascii_hex = "FFFF"; ascii_bin = "1111111111111111";
      build_exp(8'h2A, "FFFF", "1111111111111111", 25);
      pulse_start(1'b0);
      collect(0);
      compare_line("after_rst");
      // no CRLF variant
      sel = 1'b1;
      char_command = 8'h7C; ascii_hex = "0001"; ascii_bin = "0000000000000001";
      build_exp(8'h7C, "0001", "0000000000000001", 23);
      pulse_start(1'b1);
      collect(0);
      compare_line("nocrlf");
      sel = 1'b0;
      // back-to-back with start held high
      char_command = 8'h2A; ascii_hex = "FFFF"; ascii_bin = "1111111111111111";
      tx_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      pv = 1'b0; vcnt = 0;
      for (int c = 0; c < 81; c++) begin
         if (tx_valid) vcnt++;
         if (tx_valid && !pv) begin
            starts.push_back(c);
            check("b2b_first_byte", {24'd0, tx_data}, 32'h2A);
         end
         pv = tx_valid;
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_line_count", starts.size(), 3);
      if (starts.size() == 3) begin
         check("b2b_start0", starts[0], 0);
         check("b2b_period1", starts[1] - starts[0], 27);
         check("b2b_period2", starts[2] - starts[1], 27);
      end
      check("b2b_valid_cycles", vcnt, 75);
      repeat (40) @(negedge clk);
      check("b2b_drained", {31'd0, busy}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
